// File: rtl/fp_div_seq.sv
// fp_div_seq: iterative binary32 divider, 27-cycle start/done latency,
// restoring mantissa division with round-to-nearest-even and flush-to-zero.
module fp_div_seq (
   input  logic        clk,
   input  logic        rst,
   input  logic        start,
   input  logic [31:0] a,
   input  logic [31:0] b,
   output logic        busy,
   output logic        done,
   output logic [31:0] y,
   output logic        dz,
   output logic        invalid
);
   typedef enum logic [1:0] {IDLE, DIV, RND} state_t;
   typedef enum logic [1:0] {C_NORM, C_NAN, C_INF, C_ZERO} cls_t;
   state_t state_q, state_d;
   cls_t cls_q, cls_d;
   logic [4:0] cnt_q, cnt_d;
   logic [24:0] rem_q, rem_d;
   logic [23:0] rem_sub, mb_q, mb_d;
   logic [25:0] q_q, q_d;
   logic signed [9:0] e_q, e_d, e_r;
   logic s_q, s_d, dzp_q, dzp_d;
   logic busy_q, busy_d, done_q, done_d, dz_q, dz_d, inv_q, inv_d;
   logic [31:0] y_q, y_d, y_n;
   logic za, zb, ia, ib, nan_c, ge, g, st, up, c;
   logic [22:0] m0, m;
   assign busy = busy_q;
   assign done = done_q;
   assign y = y_q;
   assign dz = dz_q;
   assign invalid = inv_q;
   always_comb begin
      za = a[30:23] == 8'h00;
      zb = b[30:23] == 8'h00;
      ia = (&a[30:23]) & ~(|a[22:0]);
      ib = (&b[30:23]) & ~(|b[22:0]);
      nan_c = ((&a[30:23]) & (|a[22:0])) | ((&b[30:23]) & (|b[22:0])) | (za & zb) | (ia & ib);
      ge = rem_q >= {1'b0, mb_q};
      rem_sub = ge ? 24'(rem_q - {1'b0, mb_q}) : rem_q[23:0];
      m0 = q_q[25] ? q_q[24:2] : q_q[23:1];
      g = q_q[25] ? q_q[1] : q_q[0];
      st = (q_q[25] & q_q[0]) | (|rem_q);
      up = g & (st | m0[0]);
      {c, m} = {1'b0, m0} + {23'h0, up};
      // the leading mantissa bit is always set here, so a carry out of the fraction means 2.0
      e_r = e_q + {9'h0, q_q[25]} + {9'h0, c};
      y_n = cls_q == C_NAN ? 32'h7FC00000 :
            cls_q == C_ZERO ? {s_q, 31'h0} :
            (cls_q == C_INF || e_r >= 10'sd255) ? {s_q, 8'hFF, 23'h0} :
            e_r <= 10'sd0 ? {s_q, 31'h0} : {s_q, e_r[7:0], m};
   end
   always_comb begin
      state_d = state_q;
      cls_d = cls_q;
      cnt_d = cnt_q;
      rem_d = rem_q;
      mb_d = mb_q;
      q_d = q_q;
      e_d = e_q;
      s_d = s_q;
      dzp_d = dzp_q;
      busy_d = busy_q;
      done_d = 1'b0;
      y_d = y_q;
      dz_d = dz_q;
      inv_d = inv_q;
      case (state_q)
         IDLE: if (start) begin
            state_d = DIV;
            busy_d = 1'b1;
            cnt_d = 5'd25;
            rem_d = {2'b01, a[22:0]};
            mb_d = {1'b1, b[22:0]};
            q_d = '0;
            s_d = a[31] ^ b[31];
            e_d = $signed({2'b00, a[30:23]}) - $signed({2'b00, b[30:23]}) + 10'sd126;
            cls_d = nan_c ? C_NAN : (zb | ia) ? C_INF : (za | ib) ? C_ZERO : C_NORM;
            dzp_d = ~nan_c & zb & ~ia;
         end
         DIV: begin
            rem_d = {rem_sub, 1'b0};
            q_d = {q_q[24:0], ge};
            cnt_d = cnt_q - 5'd1;
            state_d = cnt_q == 5'd0 ? RND : DIV;
         end
         RND: begin
            state_d = IDLE;
            busy_d = 1'b0;
            done_d = 1'b1;
            y_d = y_n;
            dz_d = dzp_q;
            inv_d = cls_q == C_NAN;
         end
         default: state_d = IDLE;
      endcase
   end
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         cls_q <= C_NORM;
         cnt_q <= '0;
         rem_q <= '0;
         mb_q <= '0;
         q_q <= '0;
         e_q <= '0;
         s_q <= 1'b0;
         dzp_q <= 1'b0;
         busy_q <= 1'b0;
         done_q <= 1'b0;
         y_q <= '0;
         dz_q <= 1'b0;
         inv_q <= 1'b0;
      end else begin
         state_q <= state_d;
         cls_q <= cls_d;
         cnt_q <= cnt_d;
         rem_q <= rem_d;
         mb_q <= mb_d;
         q_q <= q_d;
         e_q <= e_d;
         s_q <= s_d;
         dzp_q <= dzp_d;
         busy_q <= busy_d;
         done_q <= done_d;
         y_q <= y_d;
         dz_q <= dz_d;
         inv_q <= inv_d;
      end
   end
endmodule

// File: doc/fp_div_seq.md
# fp_div_seq

Sequential IEEE-754 single-precision divider: the inverse operation of the team's combinational floating-point multiplier (`mul`), built as an iterative start/done unit. It computes y = a / b over a fixed 27-cycle latency using restoring mantissa division, with round-to-nearest-even and flush-to-zero denormal handling. It sits beside `mul` in the floating-point datapath, and the same vectors can cross-check the two blocks (a·b = y ⇔ y / b = a).

## Interface
- No parameters; the format is fixed at binary32.
- `clk` in 1: rising-edge clock.
- `rst` in 1: asynchronous, active-high reset.
- `start` in 1: request; sampled only in IDLE.
- `a` in 32: dividend, captured on the accepted start edge.
- `b` in 32: divisor, captured on the accepted start edge.
- `busy` out 1: operation in progress.
- `done` out 1: one-cycle pulse; `y`/flags valid from this cycle.
- `y` out 32: quotient; holds until the next `done`.
- `dz` out 1: divide-by-zero flag; updated with `done`, held.
- `invalid` out 1: invalid-operation flag; updated with `done`, held.

## Operation
- Reset values: `busy`=0, `done`=0, `y`=32'h0, `dz`=0, `invalid`=0; state IDLE.
- States: IDLE -> DIV (26 cycles, counter 25 down to 0) -> RND (1 cycle) -> IDLE.
- Unpack: s = a[31]^b[31]. Exponent 0 means zero (denormal fraction ignored, flushed). Exponent 255 means inf (frac = 0) or NaN (frac ≠ 0).
- Specials, in priority order; all still take the full latency:
  - Any NaN operand, 0/0, or inf/inf -> 32'h7FC00000, `invalid`=1.
  - finite / 0 -> {s, 8'hFF, 0}, `dz`=1.
  - inf / finite -> {s, 8'hFF, 0}.
  - 0 / x or finite / inf -> {s, 31'h0}.
- Normal path:
  - ma = {1, a[22:0]} and mb = {1, b[22:0]}, each 24 bits. Remainder is 25 bits, initialized to ma.
  - Each DIV cycle: if rem ≥ mb, then q bit = 1 and rem -= mb; else q bit = 0. Then rem <<= 1. This yields q[25:0] MSB-first, with q[25] the integer bit.
  - If q[25]=1: mant = q[25:2], guard = q[1], sticky = q[0] | (rem≠0), e = ea − eb + 127.
  - If q[25]=0: mant = q[24:1], guard = q[0], sticky = (rem≠0), e = ea − eb + 126.
  - Exponent arithmetic uses 10-bit signed values.
  - RNE: increment mant when guard & (sticky | mant[0]). A carry out of 24 bits sets mant = 24'h800000 and increments e.
  - e ≥ 255 -> {s, 8'hFF, 0} (overflow to inf).
  - e ≤ 0 -> {s, 31'h0} (underflow flush).
  - Otherwise y = {s, e[7:0], mant[22:0]}.
- `dz` and `invalid` are cleared to 0 on every `done` where their condition does not apply.

## Timing
- Start edge E0 (state IDLE, `start`=1): operands are captured and `busy`=1 from E0.
- E1..E26: the 26 division iterations.
- E27: RND completes. `y` and the flags update, `done`=1 for exactly one cycle, and `busy`=0, all from E27.
- Latency is 27 cycles from the start edge to `done`, identical for every operand class.
- `start` while `busy` is ignored and the captured operands are unaffected.
- `start` in the `done` cycle is accepted: state is already IDLE, so the next result arrives back-to-back 27 cycles later.
- `rst` mid-operation immediately (asynchronously) returns all outputs to their reset values and the state to IDLE. The aborted operation never produces `done`.
- `a` and `b` may change freely after E0.

## Test plan
- 40400000 / 3FC00000 (3.0/1.5) -> `y`=40000000, `done` 27 cycles after start, `dz`=0, `invalid`=0.
- 3F800000 / 40400000 (1/3) -> 3EAAAAAB (RNE round-up).
- 3F800000 / 00000000 -> 7F800000 with `dz`=1.
- 80000000 / 00000000 -> 7FC00000 with `invalid`=1.
- 7F800000 / 3F800000 -> 7F800000.
- 7F000000 / 3F000000 -> 7F800000 (overflow).
- 00800000 / 40000000 -> 00000000 (underflow flush).
- Handshake: pulse `start` again at cycles 5 and 26 of an operation -> both ignored, single `done`.
- Back-to-back: `start` in the `done` cycle -> second result arrives 27 cycles later.
- Reset: assert `rst` at cycle 10 -> `busy`, `done`, and `y` go to 0 with no `done`. A fresh 40800000 / 40000000 afterwards -> 40000000.
- Round-trip: for the `mul` vectors (1.5·2.0 = 3.0, 3.0·1.0 = 3.0, 1.0·1.0 = 1.0), dividing y by b returns a exactly.
